linear_layer_srl_fifo: RTL
==========================

LINEAR_LAYER_SRL_FIFO -- requirements
Module: linear_layer_srl_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per entry, >=1.
REQ-002 Parameter DEPTH, default 4: entry capacity, >=2.
REQ-003 Parameter ADDR_WIDTH, default 2: shift-register read-address width, >=clog2(DEPTH).
REQ-004 Parameter AF_THRESH, default 3: almost-full occupancy threshold, 1..DEPTH.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 if_write_ce  in  1  write clock-enable; write ignored when 0.
REQ-008 if_write  in  1  write request.
REQ-009 if_din  in  DATA_WIDTH  write data.
REQ-010 if_full_n  out  1  registered; 1 = space available.
REQ-011 if_read_ce  in  1  read clock-enable; read ignored when 0.
REQ-012 if_read  in  1  read request (pops head).
REQ-013 if_dout  out  DATA_WIDTH  head entry, combinational from storage; don't-care while if_empty_n=0.
REQ-014 if_empty_n  out  1  registered; 1 = head valid.
REQ-015 flush  in  1  synchronous discard of all entries.
REQ-016 err_clr  in  1  clears sticky error flags.
REQ-017 count  out  ADDR_WIDTH+1  registered occupancy, 0..DEPTH.
REQ-018 almost_full  out  1  registered; 1 when count >= AF_THRESH.
REQ-019 ovf_err  out  1  sticky: write attempted while full.
REQ-020 udf_err  out  1  sticky: read attempted while empty.

Function
REQ-021 Accepted write (wr_acc) SHALL be if_write & if_write_ce & if_full_n; accepted read (rd_acc) SHALL be if_read & if_read_ce & if_empty_n.
REQ-022 On wr_acc, storage SHALL shift one position (entry i -> i+1) and load if_din into entry 0; storage SHALL not shift otherwise.
REQ-023 if_dout SHALL equal storage[count-1] truncated to ADDR_WIDTH bits (oldest entry).
REQ-024 Next count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
REQ-025 if_full_n SHALL be 0 exactly when count==DEPTH; a write presented while full is blocked even if a read is accepted in the same cycle.
REQ-026 if_empty_n SHALL be 1 exactly when count>0; a read presented while empty is not accepted, and a simultaneous write is accepted.
REQ-027 Write-to-read latency: wr_acc in cycle N into empty FIFO -> if_empty_n=1 and if_dout=written data in cycle N+1.
REQ-028 Read-to-space latency: rd_acc in cycle N while full -> if_full_n=1 in cycle N+1.
REQ-029 almost_full SHALL be registered from next count (valid same cycle as count).
REQ-030 flush=1 SHALL set count=0, if_empty_n=0, if_full_n=1, almost_full=0 next cycle, overriding any same-cycle wr_acc/rd_acc; storage contents need not be cleared.
REQ-031 ovf_err SHALL set on if_write & if_write_ce & ~if_full_n; udf_err SHALL set on if_read & if_read_ce & ~if_empty_n; set takes priority over same-cycle err_clr; flush does not clear them.
REQ-032 Simultaneous wr_acc and rd_acc with 0<count<DEPTH SHALL keep count and flags constant and preserve FIFO order.

Reset
REQ-033 reset=1 SHALL force count=0, if_empty_n=0, if_full_n=1, almost_full=0, ovf_err=0, udf_err=0 next cycle, overriding flush, writes and reads.
REQ-034 Storage SHALL not be reset; reset mid-operation discards all entries.

Verification (DATA_WIDTH=8, DEPTH=4, AF_THRESH=3)
REQ-035 Write 0x11,0x22,0x33,0x44 back-to-back -> count 1..4, almost_full=1 after 3rd, if_full_n=0 after 4th; reads return 0x11,0x22,0x33,0x44 in order.
REQ-036 Full FIFO, write 0x55 with read same cycle -> write blocked, ovf_err=1, count=3, next read returns 0x22.
REQ-037 count=2, simultaneous write 0xA0 and read, 10 cycles -> count stays 2, output sequence preserves order.
REQ-038 Empty FIFO, read + write 0x7E same cycle -> udf_err=1, count=1, if_dout=0x7E next cycle; err_clr=1 -> udf_err=0.
REQ-039 count=3, flush with write -> count=0, if_empty_n=0, if_full_n=1; then write 0x5A -> if_dout=0x5A.
REQ-040 count=4 with ovf_err=1, assert reset -> all outputs at REQ-033 values next cycle.

Source files
------------

// File: rtl/linear_layer_srl_fifo.sv
// Shift-register FIFO: writes shift storage up by one, reads select the oldest
// entry by occupancy. Occupancy, flags and sticky error bits are all registered.
module linear_layer_srl_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int AF_THRESH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    input  logic                  flush,
    input  logic                  err_clr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  ovf_err,
    output logic                  udf_err
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_n_q, empty_n_q, af_q, ovf_q, udf_q;
    logic                  wr_acc, rd_acc, ovf_set, udf_set;
    logic [ADDR_WIDTH-1:0] rd_idx;

    assign wr_acc  = if_write & if_write_ce & full_n_q;
    assign rd_acc  = if_read  & if_read_ce  & empty_n_q;
    assign ovf_set = if_write & if_write_ce & ~full_n_q;
    assign udf_set = if_read  & if_read_ce  & ~empty_n_q;

    // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // NOTE: storage carries no reset; occupancy alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                mem_q[i] <= mem_q[i-1];
            end
            mem_q[0] <= if_din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
            af_q      <= 1'b0;
        end else if (flush) begin
            count_q   <= '0;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
            af_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            full_n_q  <= (count_d != CNT_W'(DEPTH));
            empty_n_q <= (count_d != '0);
            af_q      <= (count_d >= CNT_W'(AF_THRESH));
        end
    end

    // Error set wins over a same-cycle clear; flush leaves the sticky bits alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (ovf_set)      ovf_q <= 1'b1;
            else if (err_clr) ovf_q <= 1'b0;
            if (udf_set)      udf_q <= 1'b1;
            else if (err_clr) udf_q <= 1'b0;
        end
    end

    // Oldest entry sits at index count-1; a mux loop keeps non-power-of-two depths in range.
    assign rd_idx = ADDR_WIDTH'(count_q - CNT_W'(1));

    always_comb begin
        if_dout = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_idx == ADDR_WIDTH'(i)) begin
                if_dout = mem_q[i];
            end
        end
    end

    assign count       = count_q;
    assign if_full_n   = full_n_q;
    assign if_empty_n  = empty_n_q;
    assign almost_full = af_q;
    assign ovf_err     = ovf_q;
    assign udf_err     = udf_q;

endmodule
